// File: rtl/acc_alu_seq.sv
// rtl/acc_alu_seq.sv - accumulator ALU with shared tri-state bus and multi-cycle shift-add multiply
module acc_alu_seq #(
    parameter int WORD_W = 8,
    parameter int OP_W   = 3
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic              load_ACC,
    input  logic [OP_W-1:0]   op,
    input  logic              ACC_bus,
    inout  wire  [WORD_W-1:0] sysbus,
    output logic              busy,
    output logic              done,
    output logic              z_flag,
    output logic              n_flag,
    output logic              c_flag,
    output logic              v_flag
);

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WORD_W - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [OP_W-1:0] OP_LOAD = OP_W'(0);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SHR  = OP_W'(7);

    logic [0:0]          state;
    logic [WORD_W-1:0]   acc;
    logic [WORD_W-1:0]   mplier;
    logic [2*WORD_W-1:0] mcand_sh;
    logic [2*WORD_W-1:0] product;
    logic [CNT_W-1:0]    cnt;

    logic [WORD_W:0]     sum;
    logic [WORD_W:0]     diff;
    logic                add_v;
    logic                sub_v;
    logic [2*WORD_W-1:0] step_prod;

    // The accumulator is the only thing this block ever places on the shared bus.
    assign sysbus = ACC_bus ? acc : {WORD_W{1'bz}};

    assign busy   = (state == S_MUL);
    assign z_flag = (acc == '0);
    assign n_flag = acc[WORD_W-1];

    // Arithmetic results and the next partial product, computed from current state and bus.
    always_comb begin
        sum       = {1'b0, acc} + {1'b0, sysbus};
        diff      = {1'b0, acc} - {1'b0, sysbus};
        add_v     = (acc[WORD_W-1] == sysbus[WORD_W-1]) && (sum[WORD_W-1] != acc[WORD_W-1]);
        sub_v     = (acc[WORD_W-1] != sysbus[WORD_W-1]) && (diff[WORD_W-1] != acc[WORD_W-1]);
        step_prod = product + (mplier[0] ? mcand_sh : '0);
    end

    // Operation execution in IDLE and one LSB-first shift-add step per cycle in MUL.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state    <= S_IDLE;
            acc      <= '0;
            c_flag   <= 1'b0;
            v_flag   <= 1'b0;
            done     <= 1'b0;
            mplier   <= '0;
            mcand_sh <= '0;
            product  <= '0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (load_ACC) begin
                    case (op)
                        OP_LOAD: acc <= sysbus;
                        OP_ADD: begin
                            acc    <= sum[WORD_W-1:0];
                            c_flag <= sum[WORD_W];
                            v_flag <= add_v;
                        end
                        OP_SUB: begin
                            acc    <= diff[WORD_W-1:0];
                            c_flag <= diff[WORD_W];
                            v_flag <= sub_v;
                        end
                        OP_XOR: acc <= acc ^ sysbus;
                        OP_AND: acc <= acc & sysbus;
                        OP_OR:  acc <= acc | sysbus;
                        OP_MUL: begin
                            mcand_sh <= {{WORD_W{1'b0}}, acc};
                            mplier   <= sysbus;
                            product  <= '0;
                            cnt      <= '0;
                            state    <= S_MUL;
                        end
                        OP_SHR: begin
                            acc    <= acc >> 1;
                            c_flag <= acc[0];
                        end
                        default: ;
                    endcase
                end
            end else begin
                product  <= step_prod;
                mcand_sh <= mcand_sh << 1;
                mplier   <= mplier >> 1;
                cnt      <= cnt + 1'b1;
                if (cnt == LAST_STEP) begin
                    acc    <= step_prod[WORD_W-1:0];
                    c_flag <= |step_prod[2*WORD_W-1:WORD_W];
                    v_flag <= 1'b0;
                    done   <= 1'b1;
                    state  <= S_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_acc_alu_seq.sv
// tb/tb_acc_alu_seq.sv - directed self-checking bench for acc_alu_seq
module tb_acc_alu_seq;

    logic       clock;
    logic       n_reset;
    logic       load_ACC;
    logic [2:0] op;
    logic       ACC_bus;
    logic       busy, done, z_flag, n_flag, c_flag, v_flag;
    logic [7:0] tb_data;
    logic       tb_en;
    wire  [7:0] sysbus;

    int vecs;
    int errs;
    int cycles;
    int dones;
    logic [7:0] rd;

    assign sysbus = tb_en ? tb_data : 8'bz;

    acc_alu_seq #(.WORD_W(8), .OP_W(3)) dut (
        .clock    (clock),
        .n_reset  (n_reset),
        .load_ACC (load_ACC),
        .op       (op),
        .ACC_bus  (ACC_bus),
        .sysbus   (sysbus),
        .busy     (busy),
        .done     (done),
        .z_flag   (z_flag),
        .n_flag   (n_flag),
        .c_flag   (c_flag),
        .v_flag   (v_flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic read_acc(output logic [7:0] val);
        tb_en   = 1'b0;
        ACC_bus = 1'b1;
        #1;
        val     = sysbus;
        ACC_bus = 1'b0;
        #1;
    endtask

    // Present one operation at a falling edge; it executes at the following rising edge.
    task automatic apply(input logic [2:0] o, input logic [7:0] d, input logic via_acc);
        @(negedge clock);
        load_ACC = 1'b1;
        op       = o;
        tb_data  = d;
        tb_en    = !via_acc;
        ACC_bus  = via_acc;
        @(negedge clock);
        load_ACC = 1'b0;
        tb_en    = 1'b0;
        ACC_bus  = 1'b0;
    endtask

    initial begin
        vecs = 0; errs = 0;
        n_reset = 1'b0; load_ACC = 1'b0; op = 3'd0; ACC_bus = 1'b0;
        tb_data = 8'h00; tb_en = 1'b0;
        repeat (2) @(negedge clock);
        read_acc(rd);
        chk("rst_acc", rd, 8'h00);
        chk("rst_flags", {z_flag, n_flag, c_flag, v_flag, busy, done}, 6'b100000);
        n_reset = 1'b1;

        apply(3'd0, 8'hF0, 1'b0);
        apply(3'd1, 8'h20, 1'b0);
        read_acc(rd);
        chk("add_acc", rd, 8'h10);
        chk("add_flags", {z_flag, n_flag, c_flag, v_flag}, 4'b0010);

        apply(3'd0, 8'h7F, 1'b0);
        apply(3'd1, 8'h01, 1'b0);
        read_acc(rd);
        chk("addv_acc", rd, 8'h80);
        chk("addv_flags", {z_flag, n_flag, c_flag, v_flag}, 4'b0101);
        apply(3'd2, 8'h80, 1'b0);
        read_acc(rd);
        chk("sub0_acc", rd, 8'h00);
        chk("sub0_flags", {z_flag, n_flag, c_flag, v_flag}, 4'b1000);

        apply(3'd0, 8'h03, 1'b0);
        apply(3'd2, 8'h05, 1'b0);
        read_acc(rd);
        chk("borrow_acc", rd, 8'hFE);
        chk("borrow_flags", {z_flag, n_flag, c_flag, v_flag}, 4'b0110);
        apply(3'd7, 8'hAA, 1'b0);
        read_acc(rd);
        chk("shr_acc", rd, 8'h7F);
        chk("shr_flags", {z_flag, n_flag, c_flag, v_flag}, 4'b0000);

        apply(3'd0, 8'hFF, 1'b0);
        apply(3'd1, 8'h01, 1'b0);
        apply(3'd3, 8'h0F, 1'b0);
        read_acc(rd);
        chk("xor_acc", rd, 8'h0F);
        chk("xor_c_hold", {c_flag, v_flag}, 2'b10);
        apply(3'd4, 8'h3C, 1'b0);
        apply(3'd5, 8'h40, 1'b0);
        read_acc(rd);
        chk("and_or_acc", rd, 8'h4C);

        @(negedge clock);
        op = 3'd1; tb_data = 8'h11; tb_en = 1'b1; load_ACC = 1'b0;
        @(negedge clock);
        tb_en = 1'b0;
        read_acc(rd);
        chk("noload_acc", rd, 8'h4C);

        apply(3'd0, 8'h21, 1'b0);
        apply(3'd1, 8'h00, 1'b1);
        read_acc(rd);
        chk("double_acc", rd, 8'h42);

        apply(3'd0, 8'h0C, 1'b0);
        apply(3'd6, 8'h0B, 1'b0);
        cycles = 0;
        while (busy && cycles < 30) begin
            cycles++;
            load_ACC = (cycles == 3);
            op       = 3'd0;
            tb_data  = 8'h55;
            tb_en    = (cycles == 3);
            if (cycles == 5) begin
                read_acc(rd);
                chk("busy_bus_acc", rd, 8'h0C);
            end
            if (done) chk("done_early", done, 1'b0);
            @(negedge clock);
        end
        load_ACC = 1'b0; tb_en = 1'b0;
        chk("mul_busy_cycles", cycles, 8);
        chk("mul_done", done, 1'b1);
        read_acc(rd);
        chk("mul_acc", rd, 8'h84);
        chk("mul_c", c_flag, 1'b0);
        @(negedge clock);
        chk("mul_done_once", done, 1'b0);

        apply(3'd0, 8'h7F, 1'b0);
        apply(3'd1, 8'h01, 1'b0);
        apply(3'd0, 8'h10, 1'b0);
        apply(3'd6, 8'h10, 1'b0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dones++;
            @(negedge clock);
        end
        chk("mul2_done_cnt", dones, 1);
        read_acc(rd);
        chk("mul2_acc", rd, 8'h00);
        chk("mul2_flags", {z_flag, c_flag, v_flag, busy}, 4'b1100);

        apply(3'd0, 8'h05, 1'b0);
        apply(3'd6, 8'h03, 1'b0);
        repeat (3) @(negedge clock);
        @(posedge clock);
        #1 n_reset = 1'b0;
        #1;
        read_acc(rd);
        chk("abort_acc", rd, 8'h00);
        chk("abort_flags", {busy, done, z_flag, c_flag}, 4'b0010);
        dones = 0;
        repeat (2) begin
            @(negedge clock);
            if (done) dones++;
        end
        n_reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (done || busy) dones++;
            @(negedge clock);
        end
        chk("abort_no_done", dones, 0);
        apply(3'd1, 8'h01, 1'b0);
        read_acc(rd);
        chk("post_abort_acc", rd, 8'h01);
        chk("post_abort_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
